// File: rtl/instr_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_pkg
// Brief    : Shared types and constants for the instruction prefetch unit:
//            fetch FSM state encoding, PC word increment, reset PC default.
// Revision : 1.0 - initial release
// ============================================================================
package instr_prefetch_pkg;

  // Fetch FSM: IDLE (no request), REQ (live request), DISCARD (stale request
  // whose data must be dropped once it returns).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] c_word_incr        = 32'd4;
  localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage : instr_prefetch_pkg
`default_nettype wire

// File: rtl/instr_prefetch_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH x WIDTH synchronous FIFO with push, pop, flush and an
//            occupancy count. Flush wins over push/pop in the same cycle.
//            Caller guarantees no push when full and no pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Brief    : Instruction prefetch unit. Issues one word read at a time to
//            instruction memory, buffers {PC, instruction} pairs in a FIFO
//            for the core, and flushes/refetches on a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   MemReq,
  output logic [31:0]            MemAddr,
  input  logic                   MemAck,
  input  logic [31:0]            MemData,
  output logic [31:0]            Instr,
  output logic [31:0]            InstrPC,
  output logic                   InstrValid,
  input  logic                   InstrTake,
  input  logic                   Redirect,
  input  logic [31:0]            RedirectPC,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  fetch_state_e  state_q,    state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;   // next address to request
  logic [31:0]   mem_addr_q, mem_addr_d;   // address of the request on the bus

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  logic          instr_valid;
  logic          take_ok;
  logic [31:0]   redirect_pc;
  logic [31:0]   next_pc;
  logic [CW-1:0] count_after_ack;

  assign instr_valid = (fifo_count != '0);
  assign take_ok     = InstrTake & instr_valid;
  assign redirect_pc = word_align(RedirectPC);
  assign next_pc     = mem_addr_q + c_word_incr;
  // Occupancy once the returning word is pushed and any same-cycle pop applied.
  assign count_after_ack = fifo_count + CW'(1) - {{(CW-1){1'b0}}, take_ok};

  // Fetch FSM next-state and FIFO control. Redirect overrides take and push.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Redirect) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redirect_pc;
          mem_addr_d = redirect_pc;
          state_d    = ST_REQ;
        end else begin
          fifo_pop = take_ok;
          // No request outstanding here, so only the FIFO occupancy counts.
          if (fifo_count < c_depth) begin
            mem_addr_d = fetch_pc_q;
            state_d    = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (Redirect) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redirect_pc;
          if (MemAck) begin
            // Returning word belongs to the old stream: drop it, refetch now.
            mem_addr_d = redirect_pc;
            state_d    = ST_REQ;
          end else begin
            // Keep the bus address stable until the stale word comes back.
            state_d = ST_DISCARD;
          end
        end else begin
          fifo_pop = take_ok;
          if (MemAck) begin
            fifo_push  = 1'b1;
            fetch_pc_d = next_pc;
            if (count_after_ack < c_depth) begin
              mem_addr_d = next_pc;
              state_d    = ST_REQ;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_DISCARD: begin
        if (Redirect) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redirect_pc;
          if (MemAck) begin
            mem_addr_d = redirect_pc;
            state_d    = ST_REQ;
          end
        end else begin
          fifo_pop = take_ok;
          if (MemAck) begin
            // FIFO was flushed on entry, so there is always room to refetch.
            mem_addr_d = fetch_pc_q;
            state_d    = ST_REQ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch FSM and address registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data ({mem_addr_q, MemData}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign MemReq     = (state_q != ST_IDLE);
  assign MemAddr    = mem_addr_q;
  assign InstrValid = instr_valid;
  // Head is masked when empty so the core never sees stale storage.
  assign Instr      = instr_valid ? fifo_head[31:0]  : 32'h0;
  assign InstrPC    = instr_valid ? fifo_head[63:32] : 32'h0;
  assign Count      = fifo_count;

endmodule : instr_prefetch
`default_nettype wire
